// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse-rate filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_pkg;

  // Alarm state machine states
  typedef enum logic [2:0] {
    ST_NORMAL    = 3'd0,
    ST_LOW_PEND  = 3'd1,
    ST_LOW       = 3'd2,
    ST_HIGH_PEND = 3'd3,
    ST_HIGH      = 3'd4
  } alarm_state_t;

  // alarm_o encodings; 2'b11 is never produced
  localparam logic [1:0] ALARM_NORMAL = 2'b00;
  localparam logic [1:0] ALARM_LOW    = 2'b01;
  localparam logic [1:0] ALARM_HIGH   = 2'b10;

  // Default configuration
  localparam int         DEF_DEPTH   = 8;
  localparam logic [7:0] DEF_LOW_TH  = 8'd50;
  localparam logic [7:0] DEF_HIGH_TH = 8'd120;
  localparam logic [7:0] DEF_HYST    = 8'd5;
  localparam int         DEF_HOLD    = 3;

  // Only the two latched alarm states are visible outside; pending states read as normal
  function automatic logic [1:0] alarm_code(input alarm_state_t st);
    logic [1:0] code;
    code = ALARM_NORMAL;
    case (st)
      ST_LOW:  code = ALARM_LOW;
      ST_HIGH: code = ALARM_HIGH;
      default: code = ALARM_NORMAL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pulse_avg_ring.sv
// Sample ring and running sum; exposes the window mean (and window contents under PULSE_MINMAX_EN).
// Latency: sum/mean and mean_vld registered 1 cycle after an accepted write.
// Backpressure: none; a write is accepted every cycle wr_en is high and clr is low.
module pulse_avg_ring #(
  parameter int DEPTH = pulse_pkg::DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [7:0]           wr_dat,
  output logic [7:0]           mean,
  output logic                 mean_vld,
  output logic                 full
`ifdef PULSE_MINMAX_EN
  ,
  output logic [DEPTH*8-1:0]   window
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = 8 + AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [SW-1:0] sum;
  logic          accept;
  logic          last_slot;
  logic [7:0]    evicted;

  // clr wins over a coincident write: the sample is dropped
  assign accept    = wr_en & ~clr;
  assign last_slot = (wr_ptr == AW'(DEPTH - 1));
  // Until the window is full the slot being written holds nothing to remove
  assign evicted   = full ? mem[wr_ptr] : 8'd0;
  // Sum is at most DEPTH*255, so the top 8 bits are the truncated mean
  assign mean      = sum[SW-1:AW];

`ifdef PULSE_MINMAX_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_win
    assign window[g*8 +: 8] = mem[g];
  end
`endif

  // Ring storage: no reset, a slot is only read after it has been written
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Write pointer, running sum, fill flag and the mean-ready strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      sum      <= '0;
      full     <= 1'b0;
      mean_vld <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      sum      <= '0;
      full     <= 1'b0;
      mean_vld <= 1'b0;
    end else begin
      mean_vld <= accept & (full | last_slot);
      if (accept) begin
        wr_ptr <= last_slot ? '0 : wr_ptr + AW'(1);
        sum    <= sum + SW'(wr_dat) - SW'(evicted);
        if (last_slot) begin
          full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pulse_rate_filter.sv
// Windowed pulse-rate mean with hysteretic low/high alarm; min/max outputs under PULSE_MINMAX_EN.
// Latency: avg_valid_o/avg_o 2 cycles after an accepted sample; alarm_o 1 cycle after avg_valid_o.
// Backpressure: none; samples are accepted every cycle, clear_i drops a coincident sample.
module pulse_rate_filter #(
  parameter int         DEPTH   = pulse_pkg::DEF_DEPTH,
  parameter logic [7:0] LOW_TH  = pulse_pkg::DEF_LOW_TH,
  parameter logic [7:0] HIGH_TH = pulse_pkg::DEF_HIGH_TH,
  parameter logic [7:0] HYST    = pulse_pkg::DEF_HYST,
  parameter int         HOLD    = pulse_pkg::DEF_HOLD
) (
  input  logic       clk,
  input  logic       reset_count,
  input  logic [7:0] sample_i,
  input  logic       sample_valid_i,
  input  logic       clear_i,
  output logic [7:0] avg_o,
  output logic       avg_valid_o,
  output logic       full_o,
  output logic [1:0] alarm_o
`ifdef PULSE_MINMAX_EN
  ,
  output logic [7:0] min_o,
  output logic [7:0] max_o
`endif
);

  import pulse_pkg::*;

  // Exit thresholds computed wide so LOW_TH+HYST cannot wrap and HIGH_TH-HYST cannot underflow
  localparam logic [8:0] LOW_EXIT  = {1'b0, LOW_TH} + {1'b0, HYST};
  localparam int         HIGH_EXIT = int'(HIGH_TH) - int'(HYST);
  localparam logic [3:0] HOLD_CNT  = 4'(HOLD);

  logic [7:0]   ring_mean;
  logic         ring_mean_vld;
  logic         take_avg;
  alarm_state_t state_q, state_d;
  logic [3:0]   pend_q, pend_d;
  logic [3:0]   low_cnt, high_cnt;
  logic         is_low, is_high, low_exit, high_exit;
  logic         enter_low, enter_high;

`ifdef PULSE_MINMAX_EN
  logic [DEPTH*8-1:0] window;
  logic [7:0]         win_min, win_max;
`endif

  pulse_avg_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk      (clk),
    .rst      (reset_count),
    .clr      (clear_i),
    .wr_en    (sample_valid_i),
    .wr_dat   (sample_i),
    .mean     (ring_mean),
    .mean_vld (ring_mean_vld),
    .full     (full_o)
`ifdef PULSE_MINMAX_EN
    ,
    .window   (window)
`endif
  );

  // A clear in the cycle between the ring update and the output stage cancels that average
  assign take_avg = ring_mean_vld & ~clear_i;

  // Mean output stage: strobe for one cycle, hold the value between strobes
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      avg_o       <= 8'd0;
      avg_valid_o <= 1'b0;
    end else begin
      avg_valid_o <= take_avg;
      if (take_avg) begin
        avg_o <= ring_mean;
      end
    end
  end

`ifdef PULSE_MINMAX_EN
  // Window extrema across all slots; only sampled once the window is full
  always_comb begin
    win_min = window[7:0];
    win_max = window[7:0];
    for (int i = 1; i < DEPTH; i++) begin
      if (window[i*8 +: 8] < win_min) win_min = window[i*8 +: 8];
      if (window[i*8 +: 8] > win_max) win_max = window[i*8 +: 8];
    end
  end

  // Extrema output stage, aligned with the mean
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      min_o <= 8'd0;
      max_o <= 8'd0;
    end else if (take_avg) begin
      min_o <= win_min;
      max_o <= win_max;
    end
  end
`endif

  assign is_low    = (avg_o < LOW_TH);
  assign is_high   = (avg_o > HIGH_TH);
  assign low_exit  = ({1'b0, avg_o} >= LOW_EXIT);
  assign high_exit = (int'(avg_o) <= HIGH_EXIT);
  // Consecutive count including the current average
  assign low_cnt   = (state_q == ST_LOW_PEND)  ? pend_q + 4'd1 : 4'd1;
  assign high_cnt  = (state_q == ST_HIGH_PEND) ? pend_q + 4'd1 : 4'd1;

  // Alarm state and pend counter register
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state_q <= ST_NORMAL;
      pend_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Alarm next-state: evaluated only on a fresh average, clear forces NORMAL
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    enter_low  = 1'b0;
    enter_high = 1'b0;
    if (clear_i) begin
      state_d = ST_NORMAL;
      pend_d  = 4'd0;
    end else if (avg_valid_o) begin
      case (state_q)
        ST_LOW: begin
          if (is_high) begin
            enter_high = 1'b1;
          end else if (low_exit) begin
            state_d = ST_NORMAL;
            pend_d  = 4'd0;
          end
        end
        ST_HIGH: begin
          if (is_low) begin
            enter_low = 1'b1;
          end else if (high_exit) begin
            state_d = ST_NORMAL;
            pend_d  = 4'd0;
          end
        end
        default: begin
          if (is_low) begin
            enter_low = 1'b1;
          end else if (is_high) begin
            enter_high = 1'b1;
          end else begin
            state_d = ST_NORMAL;
            pend_d  = 4'd0;
          end
        end
      endcase
      if (enter_low) begin
        if (low_cnt >= HOLD_CNT) begin
          state_d = ST_LOW;
          pend_d  = 4'd0;
        end else begin
          state_d = ST_LOW_PEND;
          pend_d  = low_cnt;
        end
      end
      if (enter_high) begin
        if (high_cnt >= HOLD_CNT) begin
          state_d = ST_HIGH;
          pend_d  = 4'd0;
        end else begin
          state_d = ST_HIGH_PEND;
          pend_d  = high_cnt;
        end
      end
    end
  end

  // Alarm output decode
  always_comb begin
    alarm_o = alarm_code(state_q);
  end

endmodule

// File: tb/tb_pulse_rate_filter.sv
// Scoreboard bench for pulse_rate_filter (min/max checked when PULSE_MINMAX_EN is defined).
// Latency: expects strobes 2 cycles after the qualifying sample.
// Backpressure: none; stimulus may be back-to-back.
module tb_pulse_rate_filter;

  localparam int D       = 8;
  localparam int LOW_TH  = 50;
  localparam int HIGH_TH = 120;
  localparam int HYST    = 5;
  localparam int HOLD    = 3;

  logic       clk;
  logic       reset_count;
  logic [7:0] sample_i;
  logic       sample_valid_i;
  logic       clear_i;
  logic [7:0] avg_o;
  logic       avg_valid_o;
  logic       full_o;
  logic [1:0] alarm_o;
`ifdef PULSE_MINMAX_EN
  logic [7:0] min_o;
  logic [7:0] max_o;
`endif

  pulse_rate_filter dut (
    .clk            (clk),
    .reset_count    (reset_count),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .clear_i        (clear_i),
    .avg_o          (avg_o),
    .avg_valid_o    (avg_valid_o),
    .full_o         (full_o),
    .alarm_o        (alarm_o)
`ifdef PULSE_MINMAX_EN
    ,
    .min_o          (min_o),
    .max_o          (max_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] avg;
    logic [1:0] alarm;
    logic [7:0] mn;
    logic [7:0] mx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_rec;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_strobes = 0;
  bit   watch_high = 0;
  bit   saw_high = 0;

  // Reference model: sliding window as a queue, alarm as mode plus consecutive-run counts
  int   win[$];
  int   m_mode = 0;  // 0 normal, 1 low alarm, 2 high alarm
  int   lo_run = 0;
  int   hi_run = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_alarm(input int a);
    case (m_mode)
      1: begin
        if (a > HIGH_TH) begin m_mode = 0; lo_run = 0; hi_run = 1; end
        else if (a >= LOW_TH + HYST) begin m_mode = 0; lo_run = 0; hi_run = 0; end
      end
      2: begin
        if (a < LOW_TH) begin m_mode = 0; hi_run = 0; lo_run = 1; end
        else if (a <= HIGH_TH - HYST) begin m_mode = 0; lo_run = 0; hi_run = 0; end
      end
      default: begin
        if (a < LOW_TH) begin lo_run++; hi_run = 0; end
        else if (a > HIGH_TH) begin hi_run++; lo_run = 0; end
        else begin lo_run = 0; hi_run = 0; end
      end
    endcase
    if (m_mode == 0 && lo_run >= HOLD) begin m_mode = 1; lo_run = 0; end
    if (m_mode == 0 && hi_run >= HOLD) begin m_mode = 2; hi_run = 0; end
  endtask

  task automatic model_push(input int s);
    exp_t e;
    int   tot;
    int   mn;
    int   mx;
    win.push_back(s);
    if (win.size() > D) void'(win.pop_front());
    if (win.size() == D) begin
      tot = 0; mn = 255; mx = 0;
      foreach (win[i]) begin
        tot += win[i];
        if (win[i] < mn) mn = win[i];
        if (win[i] > mx) mx = win[i];
      end
      e.avg   = 8'(tot / D);
      e.alarm = 2'(m_mode);
      e.mn    = 8'(mn);
      e.mx    = 8'(mx);
      sb.push_back(e);
      model_alarm(tot / D);
    end
  endtask

  task automatic model_clear();
    win.delete();
    m_mode = 0; lo_run = 0; hi_run = 0;
  endtask

  // One cycle of stimulus, applied just after the rising edge
  task automatic step(input logic v, input logic [7:0] s, input logic c);
    @(posedge clk);
    #1;
    sample_valid_i = v;
    sample_i       = s;
    clear_i        = c;
    if (c) model_clear();
    else if (v) model_push(int'(s));
  endtask

  task automatic drain();
    repeat (4) step(1'b0, 8'd0, 1'b0);
  endtask

  task automatic send_n(input int n, input logic [7:0] s);
    for (int i = 0; i < n; i++) step(1'b1, s, 1'b0);
  endtask

  task automatic do_clear(input logic with_sample, input logic [7:0] s);
    drain();
    step(with_sample, s, 1'b1);
    step(1'b0, 8'd0, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every strobe
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_count && avg_valid_o) begin
        n_strobes++;
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          mon_rec = sb.pop_front();
          check("avg", avg_o, mon_rec.avg);
          check("full_at_strobe", full_o, 32'd1);
          check("alarm_at_strobe", alarm_o, mon_rec.alarm);
`ifdef PULSE_MINMAX_EN
          check("min", min_o, mon_rec.mn);
          check("max", max_o, mon_rec.mx);
`endif
        end
      end
      if (watch_high && alarm_o == 2'b10) saw_high = 1;
    end
  end

  int base;
  int phase;
  int r;
  logic [7:0] rs;

  initial begin
    reset_count    = 1'b1;
    sample_i       = 8'd0;
    sample_valid_i = 1'b0;
    clear_i        = 1'b0;
    #22;
    check("rst_avg", avg_o, 32'd0);
    check("rst_avg_valid", avg_valid_o, 32'd0);
    check("rst_full", full_o, 32'd0);
    check("rst_alarm", alarm_o, 32'd0);
    @(posedge clk);
    #1;
    reset_count = 1'b0;
    repeat (5) step(1'b0, 8'd0, 1'b0);
    check("no_strobe_after_release", n_strobes, 32'd0);

    // 7 samples give no average, the 8th does
    send_n(7, 8'd72);
    drain();
    check("full_after_7", full_o, 32'd0);
    check("strobes_after_7", n_strobes, 32'd0);
    send_n(1, 8'd72);
    drain();
    check("strobes_after_8", n_strobes, 32'd1);
    check("avg_72", avg_o, 32'd72);
    check("full_after_8", full_o, 32'd1);

    // Saturated window, back-to-back
    base = n_strobes;
    send_n(8, 8'd255);
    drain();
    check("strobes_255", n_strobes - base, 32'd8);
    check("avg_255", avg_o, 32'd255);

    // Low alarm with hysteresis exit
    do_clear(1'b0, 8'd0);
    send_n(10, 8'd40);
    drain();
    check("alarm_low_3rd", alarm_o, 32'd1);
    send_n(8, 8'd52);
    drain();
    check("alarm_low_hold_52", alarm_o, 32'd1);
    send_n(8, 8'd55);
    drain();
    check("alarm_exit_55", alarm_o, 32'd0);

    // Averages 130,130,100: high pend aborted
    do_clear(1'b0, 8'd0);
    watch_high = 1;
    step(1'b1, 8'd130, 1'b0);
    step(1'b1, 8'd250, 1'b0);
    send_n(6, 8'd110);
    step(1'b1, 8'd130, 1'b0);
    step(1'b1, 8'd10, 1'b0);
    drain();
    watch_high = 0;
    check("avg_100", avg_o, 32'd100);
    check("pend_abort_alarm", alarm_o, 32'd0);
    check("never_high", saw_high, 32'd0);

    // Clear with a coincident sample, from a latched low alarm and mid-window
    send_n(11, 8'd30);
    drain();
    check("alarm_low_30", alarm_o, 32'd1);
    do_clear(1'b1, 8'd30);
    check("clear_full", full_o, 32'd0);
    check("clear_alarm", alarm_o, 32'd0);
    send_n(4, 8'd90);
    step(1'b1, 8'd90, 1'b1);
    step(1'b0, 8'd0, 1'b0);
    check("midclear_full", full_o, 32'd0);
    check("midclear_alarm", alarm_o, 32'd0);
    base = n_strobes;
    send_n(7, 8'd90);
    drain();
    check("midclear_strobes_7", n_strobes - base, 32'd0);
    send_n(1, 8'd90);
    drain();
    check("midclear_strobes_8", n_strobes - base, 32'd1);
    check("midclear_avg", avg_o, 32'd90);

    // Randomized traffic against the model
    phase = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) phase = int'($urandom_range(0, 3));
      case (phase)
        0: rs = 8'($urandom_range(15, 65));
        1: rs = 8'($urandom_range(40, 140));
        2: rs = 8'($urandom_range(100, 255));
        default: rs = 8'($urandom_range(0, 255));
      endcase
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_clear(1'($urandom_range(0, 1)), rs);
      end else if (r < 20) begin
        step(1'b0, 8'd0, 1'b0);
      end else begin
        step(1'b1, rs, 1'b0);
      end
    end
    drain();
    check("rand_sb_empty", sb.size(), 32'd0);
    check("rand_alarm", alarm_o, 32'(m_mode));

    // Asynchronous reset while the high alarm is latched
    do_clear(1'b0, 8'd0);
    send_n(11, 8'd200);
    drain();
    check("alarm_high", alarm_o, 32'd2);
    check("sb_empty", sb.size(), 32'd0);
    @(negedge clk);
    #2;
    reset_count = 1'b1;
    #1;
    check("arst_avg", avg_o, 32'd0);
    check("arst_avg_valid", avg_valid_o, 32'd0);
    check("arst_full", full_o, 32'd0);
    check("arst_alarm", alarm_o, 32'd0);
`ifdef PULSE_MINMAX_EN
    check("arst_min", min_o, 32'd0);
    check("arst_max", max_o, 32'd0);
`endif
    #20;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
